// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the writeback path.
//   XLEN       : architectural data width
//   REG_ADDR_W : register index width
//   NUM_REGS   : architectural integer register count
//   wb_entry_t : one pending register-file write {rd_addr, data}
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer: plain synchronous FIFO, no arbitration.
// Ports:
//   clk, rst      : clock, async active-high reset (flushes the queue)
//   i_push/i_wdata: write one entry (caller guarantees !o_full)
//   i_pop/o_rdata : o_rdata is the head; i_pop retires it (caller guarantees !o_empty)
//   o_full/o_empty/o_count : occupancy, all decoded from the registered count
module wb_load_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/wb_merge_stage.sv
// Writeback merge stage in front of the register-file write port.
// Merges in-order pipeline results with out-of-order load returns (buffered
// in wb_load_fifo), registers the selected write, and tracks outstanding
// loads in a per-register busy scoreboard.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   ex_valid_i/ex_rd_addr_i/ex_data_i : pipeline result, never back-pressured
//   ld_valid_i/ld_ready_o/ld_rd_addr_i/ld_data_i : load return handshake
//   ld_issue_i/ld_issue_rd_i     : load issued to memory this cycle
//   rd_addr_o/rd_data_o/reg_write_en_o : registered register-file write
//   busy_o                       : bit r set while a load to xr is outstanding
//   waw_err_o                    : sticky, pipeline wrote a busy register
module wb_merge_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]       ex_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_rd_addr_i,
  input  logic [XLEN-1:0]       ld_data_i,
  input  logic                  ld_issue_i,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  reg_write_en_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic                  waw_err_o
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  wb_entry_t            w_push_ent;
  wb_entry_t            w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ex_win;
  logic                 w_ld_wr;
  logic [NUM_REGS-1:1]  w_set;
  logic [NUM_REGS-1:1]  w_clr;

  logic                 r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]      r_data;
  logic [NUM_REGS-1:1]  r_busy;
  logic                 r_waw;

  // Ready is held low through reset so nothing is pushed into a queue that
  // is being flushed.
  assign ld_ready_o = !rst && (w_count < CNT_W'(LQ_DEPTH));
  assign w_push     = ld_valid_i && !w_full;

  assign w_push_ent.rd_addr = ld_rd_addr_i;
  assign w_push_ent.data    = ld_data_i;

  // x0 pipeline results are dropped outright and leave the port to the queue.
  assign w_ex_win = ex_valid_i && (ex_rd_addr_i != '0);
  assign w_pop    = !w_ex_win && !w_empty;
  // A popped x0 load is discarded: it consumes its pop slot but writes nothing.
  assign w_ld_wr  = w_pop && (w_head.rd_addr != '0);

  wb_load_fifo #(
    .W     ($bits(wb_entry_t)),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ld_issue_i && (ld_issue_rd_i != '0)) w_set[ld_issue_rd_i] = 1'b1;
    if (w_ld_wr)                             w_clr[w_head.rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_busy <= '0;
      r_waw  <= 1'b0;
    end else begin
      r_we <= w_ex_win || w_ld_wr;
      if (w_ex_win) begin
        r_addr <= ex_rd_addr_i;
        r_data <= ex_data_i;
      end else if (w_ld_wr) begin
        r_addr <= w_head.rd_addr;
        r_data <= w_head.data;
      end
      // Set applied after clear so a re-issue to the same register wins.
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_ex_win && busy_o[ex_rd_addr_i]) r_waw <= 1'b1;
    end
  end

  assign reg_write_en_o = r_we;
  assign rd_addr_o      = r_addr;
  assign rd_data_o      = r_data;
  assign busy_o         = {r_busy, 1'b0};
  assign waw_err_o      = r_waw;
endmodule

// File: tb/tb_wb_merge_stage.sv
module tb_wb_merge_stage;
  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i, ld_valid_i, ld_issue_i;
  logic [4:0]  ex_rd_addr_i, ld_rd_addr_i, ld_issue_rd_i;
  logic [31:0] ex_data_i, ld_data_i;
  logic        ld_ready_o, reg_write_en_o, waw_err_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [31:0] busy_o;

  int n_pass = 0;
  int n_total = 0;

  wb_merge_stage #(.XLEN(32), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_data_i(ex_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_rd_addr_i(ld_rd_addr_i), .ld_data_i(ld_data_i),
    .ld_issue_i(ld_issue_i), .ld_issue_rd_i(ld_issue_rd_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_write_en_o(reg_write_en_o),
    .busy_o(busy_o), .waw_err_o(waw_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_valid_i = 0; ex_rd_addr_i = 0; ex_data_i = 0;
    ld_valid_i = 0; ld_rd_addr_i = 0; ld_data_i = 0;
    ld_issue_i = 0; ld_issue_rd_i = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    cyc();
    n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL rst_we got=%0b exp=0", reg_write_en_o); else n_pass++;
    n_total++; if (rd_addr_o !== 5'd0) $display("FAIL rst_addr got=%0d exp=0", rd_addr_o); else n_pass++;
    n_total++; if (rd_data_o !== 32'd0) $display("FAIL rst_data got=%h exp=0", rd_data_o); else n_pass++;
    n_total++; if (busy_o !== 32'd0) $display("FAIL rst_busy got=%h exp=0", busy_o); else n_pass++;
    n_total++; if (waw_err_o !== 1'b0) $display("FAIL rst_waw got=%0b exp=0", waw_err_o); else n_pass++;
    n_total++; if (ld_ready_o !== 1'b0) $display("FAIL rst_ready got=%0b exp=0", ld_ready_o); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (ld_ready_o !== 1'b1) $display("FAIL rel_ready got=%0b exp=1", ld_ready_o); else n_pass++;
  endtask

  task automatic test_pipeline;
    idle();
    ex_valid_i = 1; ex_rd_addr_i = 5'd3; ex_data_i = 32'h1234;
    cyc();
    n_total++; if (reg_write_en_o !== 1'b1) $display("FAIL pipe_we got=%0b exp=1", reg_write_en_o); else n_pass++;
    n_total++; if (rd_addr_o !== 5'd3) $display("FAIL pipe_addr got=%0d exp=3", rd_addr_o); else n_pass++;
    n_total++; if (rd_data_o !== 32'h1234) $display("FAIL pipe_data got=%h exp=1234", rd_data_o); else n_pass++;
    ex_rd_addr_i = 5'd0; ex_data_i = 32'h55;
    cyc();
    n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL pipe_x0_we got=%0b exp=0", reg_write_en_o); else n_pass++;
    idle();
    cyc();
    n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL pipe_idle_we got=%0b exp=0", reg_write_en_o); else n_pass++;
  endtask

  task automatic test_load;
    idle();
    ld_issue_i = 1; ld_issue_rd_i = 5'd7;
    cyc();
    n_total++; if (busy_o[7] !== 1'b1) $display("FAIL ld_busy_set got=%0b exp=1", busy_o[7]); else n_pass++;
    idle();
    ld_valid_i = 1; ld_rd_addr_i = 5'd7; ld_data_i = 32'hDEADBEEF;
    cyc();
    idle();
    n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL ld_early_we got=%0b exp=0", reg_write_en_o); else n_pass++;
    cyc();
    n_total++; if (reg_write_en_o !== 1'b1) $display("FAIL ld_we got=%0b exp=1", reg_write_en_o); else n_pass++;
    n_total++; if (rd_addr_o !== 5'd7) $display("FAIL ld_addr got=%0d exp=7", rd_addr_o); else n_pass++;
    n_total++; if (rd_data_o !== 32'hDEADBEEF) $display("FAIL ld_data got=%h exp=deadbeef", rd_data_o); else n_pass++;
    n_total++; if (busy_o[7] !== 1'b0) $display("FAIL ld_busy_clr got=%0b exp=0", busy_o[7]); else n_pass++;
    cyc();
    n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL ld_single_we got=%0b exp=0", reg_write_en_o); else n_pass++;
  endtask

  task automatic test_contention;
    int li, acc;
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];
    int          got_c[$];
    idle();
    li = 0; acc = 0;
    for (int c = 0; c < 16; c++) begin
      ex_valid_i = (c < 6); ex_rd_addr_i = 5'(20 + c); ex_data_i = 32'(c);
      ld_valid_i = (li < 3); ld_rd_addr_i = 5'(8 + li); ld_data_i = 32'h800 + 32'(li);
      if (c == 5) begin
        n_total++; if (ld_ready_o !== 1'b0) $display("FAIL cont_ready got=%0b exp=0", ld_ready_o); else n_pass++;
      end
      if (c == 6) begin
        n_total++; if (acc !== 2) $display("FAIL cont_accepted got=%0d exp=2", acc); else n_pass++;
        n_total++; if (ld_ready_o !== 1'b0) $display("FAIL cont_ready_nopop got=%0b exp=0", ld_ready_o); else n_pass++;
      end
      if (ld_valid_i && ld_ready_o) begin
        li++;
        if (c < 6) acc++;
      end
      cyc();
      if (c < 6) begin
        n_total++;
        if (reg_write_en_o !== 1'b1 || rd_addr_o !== 5'(20 + c))
          $display("FAIL cont_ex c=%0d got we=%0b addr=%0d exp we=1 addr=%0d", c, reg_write_en_o, rd_addr_o, 20 + c);
        else n_pass++;
      end
      if (reg_write_en_o && rd_addr_o >= 5'd8 && rd_addr_o <= 5'd10) begin
        got_a.push_back(rd_addr_o); got_d.push_back(rd_data_o); got_c.push_back(c);
      end
    end
    idle();
    n_total++; if (got_a.size() !== 3) $display("FAIL cont_nwrites got=%0d exp=3", got_a.size()); else n_pass++;
    for (int k = 0; k < got_a.size() && k < 3; k++) begin
      n_total++;
      if (got_a[k] !== 5'(8 + k) || got_d[k] !== 32'h800 + 32'(k) || got_c[k] !== got_c[0] + k)
        $display("FAIL cont_order k=%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                 k, got_a[k], got_d[k], got_c[k], 8 + k, 32'h800 + 32'(k), got_c[0] + k);
      else n_pass++;
    end
  endtask

  task automatic test_setclr;
    idle();
    ld_issue_i = 1; ld_issue_rd_i = 5'd6;
    cyc();
    idle();
    ld_valid_i = 1; ld_rd_addr_i = 5'd6; ld_data_i = 32'h66;
    cyc();
    idle();
    ld_issue_i = 1; ld_issue_rd_i = 5'd6;  // pop of x6 happens this cycle
    cyc();
    idle();
    n_total++; if (reg_write_en_o !== 1'b1 || rd_addr_o !== 5'd6)
      $display("FAIL sc_write got we=%0b addr=%0d exp we=1 addr=6", reg_write_en_o, rd_addr_o); else n_pass++;
    n_total++; if (busy_o[6] !== 1'b1) $display("FAIL sc_busy got=%0b exp=1", busy_o[6]); else n_pass++;
  endtask

  task automatic test_waw;
    idle();
    ld_issue_i = 1; ld_issue_rd_i = 5'd12;
    cyc();
    idle();
    n_total++; if (waw_err_o !== 1'b0) $display("FAIL waw_pre got=%0b exp=0", waw_err_o); else n_pass++;
    ex_valid_i = 1; ex_rd_addr_i = 5'd12; ex_data_i = 32'hC;
    cyc();
    idle();
    n_total++; if (reg_write_en_o !== 1'b1 || rd_addr_o !== 5'd12 || rd_data_o !== 32'hC)
      $display("FAIL waw_write got we=%0b addr=%0d data=%h exp we=1 addr=12 data=c", reg_write_en_o, rd_addr_o, rd_data_o); else n_pass++;
    n_total++; if (waw_err_o !== 1'b1) $display("FAIL waw_set got=%0b exp=1", waw_err_o); else n_pass++;
    cyc(); cyc(); cyc();
    n_total++; if (waw_err_o !== 1'b1) $display("FAIL waw_sticky got=%0b exp=1", waw_err_o); else n_pass++;
  endtask

  task automatic test_reset_midstream;
    idle();
    ex_valid_i = 1; ex_rd_addr_i = 5'd1; ex_data_i = 32'h11;
    ld_issue_i = 1; ld_issue_rd_i = 5'd5;
    ld_valid_i = 1; ld_rd_addr_i = 5'd14; ld_data_i = 32'hE;
    cyc();
    ld_issue_i = 0;
    ld_rd_addr_i = 5'd15; ld_data_i = 32'hF;
    cyc();
    ld_valid_i = 0;
    n_total++; if (busy_o[5] !== 1'b1 || ld_ready_o !== 1'b0)
      $display("FAIL mid_pre got busy5=%0b ready=%0b exp busy5=1 ready=0", busy_o[5], ld_ready_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (reg_write_en_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 32'd0)
      $display("FAIL mid_rst_out got we=%0b addr=%0d data=%h exp 0", reg_write_en_o, rd_addr_o, rd_data_o); else n_pass++;
    n_total++; if (busy_o !== 32'd0 || waw_err_o !== 1'b0 || ld_ready_o !== 1'b0)
      $display("FAIL mid_rst_state got busy=%h waw=%0b ready=%0b exp 0", busy_o, waw_err_o, ld_ready_o); else n_pass++;
    idle();
    cyc();
    rst = 1'b0;
    #1;
    n_total++; if (ld_ready_o !== 1'b1 || busy_o !== 32'd0)
      $display("FAIL mid_rel got ready=%0b busy=%h exp ready=1 busy=0", ld_ready_o, busy_o); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_total++; if (reg_write_en_o !== 1'b0) $display("FAIL mid_stale k=%0d got we=%0b exp=0", k, reg_write_en_o); else n_pass++;
    end
  endtask

  // Transaction-level reference: a queue of pending loads, a busy bit array
  // and the expected write for the next cycle.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

  task automatic test_random;
    ent_t        q[$];
    ent_t        h;
    logic [31:0] m_busy;
    logic        m_waw, m_we, m_rdy;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    do_reset();
    m_busy = 0; m_waw = 0;
    for (int c = 0; c < 300; c++) begin
      ex_valid_i    = ($urandom_range(0, 99) < 45);
      ex_rd_addr_i  = 5'($urandom_range(0, 15));
      ex_data_i     = $urandom;
      ld_valid_i    = ($urandom_range(0, 99) < 60);
      ld_rd_addr_i  = 5'($urandom_range(0, 15));
      ld_data_i     = $urandom;
      ld_issue_i    = ($urandom_range(0, 99) < 30);
      ld_issue_rd_i = 5'($urandom_range(0, 15));
      m_rdy = (q.size() < LQ_DEPTH);
      n_total++; if (ld_ready_o !== m_rdy) $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, ld_ready_o, m_rdy); else n_pass++;
      m_we = 0; m_addr = 0; m_data = 0;
      if (ex_valid_i && ex_rd_addr_i != 0) begin
        m_we = 1; m_addr = ex_rd_addr_i; m_data = ex_data_i;
        if (m_busy[ex_rd_addr_i]) m_waw = 1;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.rd != 0) begin
          m_we = 1; m_addr = h.rd; m_data = h.d;
          m_busy[h.rd] = 1'b0;
        end
      end
      if (ld_valid_i && m_rdy) q.push_back('{ld_rd_addr_i, ld_data_i});
      if (ld_issue_i && ld_issue_rd_i != 0) m_busy[ld_issue_rd_i] = 1'b1;
      cyc();
      n_total++; if (reg_write_en_o !== m_we) $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, reg_write_en_o, m_we); else n_pass++;
      if (m_we) begin
        n_total++; if (rd_addr_o !== m_addr || rd_data_o !== m_data)
          $display("FAIL rnd_wr c=%0d got addr=%0d data=%h exp addr=%0d data=%h", c, rd_addr_o, rd_data_o, m_addr, m_data); else n_pass++;
      end
      n_total++; if (busy_o !== m_busy) $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy_o, m_busy); else n_pass++;
      n_total++; if (waw_err_o !== m_waw) $display("FAIL rnd_waw c=%0d got=%0b exp=%0b", c, waw_err_o, m_waw); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_pipeline();
    test_load();
    test_contention();
    test_setclr();
    test_waw();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
